mode6_sub_pipe: RTL and testbench
=================================

MODE6_SUB_PIPE -- requirements
Module: mode6_sub_pipe

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, giving the number of parallel subtraction lanes (1..16).
REQ-002 SHALL have parameter DATAWIDTH, default 16, giving the IEEE half-precision word width; only 16 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port b_load, input, 1, which captures b_inp into the held subtrahend.
REQ-006 SHALL have port b_inp, input, DATAWIDTH, the subtrahend value (running max or log-sum).
REQ-007 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-009 SHALL have port a_inp, input, NUM_LANES*DATAWIDTH, minuend lanes; lane i is bits [i*DATAWIDTH +: DATAWIDTH].
REQ-010 SHALL have port in_last, input, 1, last-beat-of-vector marker.
REQ-011 SHALL have port out_valid, output, 1, result beat valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-013 SHALL have port outp, output, NUM_LANES*DATAWIDTH, results with the same lane packing as a_inp.
REQ-014 SHALL have port out_last, output, 1, in_last delayed with its beat.
REQ-015 SHALL have port clamp_hit, output, 1, at least one lane of the current out beat was clamped.
REQ-016 SHALL have port beat_count, output, 16, number of beats delivered (out_valid&&out_ready).

Function
REQ-017 SHALL compute each lane as outp_i = a_i - b_held in IEEE fp16, round-to-nearest-even, with DW_fp_sub-equivalent results (rnd=3'b000).
REQ-018 SHALL accept a beat when in_valid&&in_ready, and deliver it when out_valid&&out_ready.
REQ-019 SHALL use a 2-stage pipeline: S1 registers a_inp, in_last and the effective b; S2 registers the difference, out_last and clamp_hit.
REQ-020 SHALL present a beat accepted at edge k on outp with out_valid=1 after edge k+1 (latency 2) when out_ready is held high.
REQ-021 SHALL sustain throughput of 1 beat/cycle while out_ready=1.
REQ-022 SHALL have S2 load when !s2_valid||out_ready, S1 advance when !s1_valid||S2 loads, and in_ready = !s1_valid||S2 loads.
REQ-023 SHALL never drop or duplicate a beat under backpressure, and SHALL hold outp, out_last and clamp_hit stable while out_valid&&!out_ready.
REQ-024 SHALL load b_held from b_inp at the edge where b_load=1; b_held is unaffected otherwise.
REQ-025 SHALL, when b_load and beat acceptance coincide, make that beat use the new b_inp (bypass); earlier beats in flight keep their captured b.
REQ-026 SHALL have beat_count increment by 1 per delivered beat and wrap from 0xFFFF to 0x0000.
REQ-027 SHALL pass NaN and infinity per IEEE: inf-inf gives a NaN with exponent all ones and nonzero mantissa.

Reset
REQ-028 SHALL, when resetn=0 at a clock edge, clear s1_valid, s2_valid, out_valid, out_last, clamp_hit and beat_count to 0, set outp to 0 and set b_held to 0x0000.
REQ-029 SHALL hold in_ready=0 while resetn=0.
REQ-030 SHALL discard in-flight beats on reset mid-operation; none may appear after reset deasserts.

Configuration
REQ-031 SHALL, when macro MODE6_SUB_CLAMP_EN is defined, replace any lane result with sign=0 and nonzero magnitude (not NaN) by 0x0000 and set clamp_hit for that beat.
REQ-032 SHALL, when MODE6_SUB_CLAMP_EN is undefined, pass results unmodified, tie clamp_hit to 0 and omit the clamp logic.

Verification
REQ-033 SHALL cover: b_load with b_inp=0x3C00, then lane0 a=0x4000 -> outp lane0=0x3C00 two cycles after acceptance, beat_count=1.
REQ-034 SHALL cover: a=0x3C00, b=0x4000 -> 0xBC00 with clamp off; with MODE6_SUB_CLAMP_EN -> a=0x4400, b=0x3C00 gives 0x0000 and clamp_hit=1.
REQ-035 SHALL cover: out_ready=0 for 4 cycles with in_valid held -> exactly 2 beats accepted, then in_ready=0; on release all beats arrive in order, beat_count=2.
REQ-036 SHALL cover: b_load (0x4000) in the same cycle as acceptance of a beat, previous b=0x3C00 -> that beat uses 0x4000; the prior beat uses 0x3C00.
REQ-037 SHALL cover: resetn=0 with 2 beats in flight -> out_valid=0 and beat_count=0 next cycle, and no stale beat afterwards.
REQ-038 SHALL cover: 65536 delivered beats -> beat_count wraps to 0x0000; NUM_LANES=1 and 16 builds pass the same tests.

Source files
------------

// File: rtl/mode6_sub_pipe.sv
// -----------------------------------------------------------------------------
// mode6_sub_pipe
//   Two-stage, NUM_LANES-wide IEEE fp16 subtractor: outp_i = a_i - b_held,
//   round-to-nearest-even, gradual underflow, IEEE NaN/infinity handling.
//   Used to subtract a running max or log-sum from a vector, one beat per cycle.
//
//   Stage S1 registers a_inp, in_last and the effective subtrahend.
//   Stage S2 registers the lane differences, out_last and clamp_hit.
//   Valid/ready handshake on both sides. Full throughput, latency 2.
//
// Optional feature (macro MODE6_SUB_CLAMP_EN):
//   when defined, any positive, nonzero, non-NaN lane result is replaced by
//   0x0000 and clamp_hit flags the beat. When undefined, results pass
//   unmodified and clamp_hit is tied low.
//
// Parameters
//   NUM_LANES  number of parallel lanes (1..16)
//   DATAWIDTH  word width; only 16 (fp16) is supported
//
// Ports
//   clk         clock, rising edge
//   resetn      synchronous active-low reset
//   b_load      capture b_inp into the held subtrahend
//   b_inp       subtrahend value
//   in_valid    input beat valid
//   in_ready    block can accept a beat (low while in reset)
//   a_inp       minuend lanes, lane i = [i*DATAWIDTH +: DATAWIDTH]
//   in_last     last-beat-of-vector marker
//   out_valid   result beat valid
//   out_ready   downstream accepts the beat
//   outp        result lanes, same packing as a_inp
//   out_last    in_last travelling with its beat
//   clamp_hit   at least one lane of the current out beat was clamped
//   beat_count  delivered beats, wraps at 16 bits
// -----------------------------------------------------------------------------
module mode6_sub_pipe #(
  parameter int NUM_LANES = 4,
  parameter int DATAWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           b_load,
  input  logic [DATAWIDTH-1:0]           b_inp,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*DATAWIDTH-1:0] a_inp,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*DATAWIDTH-1:0] outp,
  output logic                           out_last,
  output logic                           clamp_hit,
  output logic [15:0]                    beat_count
);

  localparam int W = NUM_LANES * DATAWIDTH;

  // fp16 a - b, round-to-nearest-even, subnormals handled, quiet NaN 0x7E00.
  function automatic logic [15:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] nb, x, y, r;
    logic        a_nan, b_nan, a_inf, b_inf, eff_sub, inc;
    logic [10:0] mx, my;
    logic [4:0]  ex, ey, d;
    logic [31:0] sh;
    logic [13:0] ax, ay, n;
    logic [14:0] s;
    logic [5:0]  e;
    logic [11:0] m;
    nb    = {~b[15], b[14:0]};
    a_nan = (a[14:10] == 5'h1F) && (|a[9:0]);
    b_nan = (b[14:10] == 5'h1F) && (|b[9:0]);
    a_inf = (a[14:10] == 5'h1F) && !(|a[9:0]);
    b_inf = (b[14:10] == 5'h1F) && !(|b[9:0]);
    // Order by magnitude so the aligned subtraction never goes negative.
    if (a[14:0] >= nb[14:0]) begin
      x = a;
      y = nb;
    end else begin
      x = nb;
      y = a;
    end
    mx = {|x[14:10], x[9:0]};
    my = {|y[14:10], y[9:0]};
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    d  = ex - ey;
    // Hidden bit lands at bit 13; bits 2..0 are guard, round, sticky.
    sh = {my, 21'd0} >> d;
    ax = {mx, 3'b000};
    ay = {sh[31:19], sh[18] | (|sh[17:0])};
    eff_sub = x[15] ^ y[15];
    s = eff_sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
    e = {1'b0, ex};
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      n = s[13:0];
    end
    // Left-normalise, stopping at the subnormal exponent.
    for (int i = 0; i < 13; i++) begin
      if (!n[13] && (e > 6'd1)) begin
        n = n << 1;
        e = e - 6'd1;
      end
    end
    inc = n[2] & (n[1] | n[0] | n[3]);
    m   = {1'b0, n[13:3]} + {11'd0, inc};
    if (m[11]) begin
      m = m >> 1;
      e = e + 6'd1;
    end
    if (s == 15'd0)
      r = {eff_sub ? 1'b0 : x[15], 15'd0};   // exact cancellation gives +0
    else if (e >= 6'd31)
      r = {x[15], 5'h1F, 10'd0};
    else
      r = {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};  // rounding up into normal range sets exp=1
    if (a_nan || b_nan)
      r = 16'h7E00;
    else if (a_inf && b_inf)
      r = (a[15] == b[15]) ? 16'h7E00 : a;
    else if (a_inf)
      r = a;
    else if (b_inf)
      r = {~b[15], 15'h7C00};
    return r;
  endfunction

  logic                 s1_valid, s1_last;
  logic [W-1:0]         s1_a;
  logic [DATAWIDTH-1:0] s1_b, b_held, b_eff;
  logic                 s2_valid, s2_last;
  logic [W-1:0]         s2_data, res_vec;
  logic                 s2_load, s1_adv;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = resetn && s1_adv;
  // A beat accepted together with b_load uses the incoming value.
  assign b_eff    = b_load ? b_inp : b_held;

`ifdef MODE6_SUB_CLAMP_EN
  logic [NUM_LANES-1:0] clamp_vec;
  logic                 s2_clamp;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [15:0] diff;
    assign diff = fp16_sub(s1_a[gi*DATAWIDTH +: DATAWIDTH], s1_b);
`ifdef MODE6_SUB_CLAMP_EN
    assign clamp_vec[gi] = !diff[15] && (|diff[14:0]) &&
                           !((diff[14:10] == 5'h1F) && (|diff[9:0]));
    assign res_vec[gi*DATAWIDTH +: DATAWIDTH] = clamp_vec[gi] ? 16'h0000 : diff;
`else
    assign res_vec[gi*DATAWIDTH +: DATAWIDTH] = diff;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      b_held     <= 16'h0000;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_data    <= '0;
      beat_count <= 16'd0;
`ifdef MODE6_SUB_CLAMP_EN
      s2_clamp   <= 1'b0;
`endif
    end else begin
      if (b_load)
        b_held <= b_inp;
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= a_inp;
          s1_last <= in_last;
          s1_b    <= b_eff;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res_vec;
          s2_last <= s1_last;
`ifdef MODE6_SUB_CLAMP_EN
          s2_clamp <= |clamp_vec;
`endif
        end
      end
      if (s2_valid && out_ready)
        beat_count <= beat_count + 16'd1;
    end
  end

  assign out_valid = s2_valid;
  assign outp      = s2_data;
  assign out_last  = s2_last;
`ifdef MODE6_SUB_CLAMP_EN
  assign clamp_hit = s2_clamp;
`else
  assign clamp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mode6_sub_pipe.sv
// -----------------------------------------------------------------------------
// tb_mode6_sub_pipe
//   Self-checking bench for mode6_sub_pipe. Expected lane results come from a
//   real-number model: decode fp16 to real, subtract exactly, round the real
//   back to fp16 (nearest-even), then apply the optional clamp rule.
// -----------------------------------------------------------------------------
module tb_mode6_sub_pipe;
  parameter int NUM_LANES = 4;
  localparam int W = NUM_LANES * 16;

  logic clk = 1'b0;
  logic resetn, b_load, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, clamp_hit;
  logic [15:0] b_inp, beat_count;
  logic [W-1:0] a_inp, outp;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         clamp;
  } beat_t;

  beat_t exp_q[$];
  logic [15:0] model_b;

  always #5 clk = ~clk;

  mode6_sub_pipe #(.NUM_LANES(NUM_LANES), .DATAWIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .b_load(b_load), .b_inp(b_inp),
    .in_valid(in_valid), .in_ready(in_ready), .a_inp(a_inp), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp),
    .out_last(out_last), .clamp_hit(clamp_hit), .beat_count(beat_count)
  );

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic bit is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real mag;
    if (h[14:10] == 5'd0) mag = real'(h[9:0]) * pow2(-24);
    else                  mag = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -mag : mag;
  endfunction

  // Round a nonzero real to the nearest fp16 (ties to even).
  function automatic logic [15:0] r2h(input real v);
    real m, t, q, fl, r;
    int e, qe;
    longint k;
    logic s;
    s = (v < 0.0);
    m = s ? -v : v;
    t = m; e = 0;
    while (t >= 2.0) begin t = t / 2.0; e++; end
    while (t < 1.0)  begin t = t * 2.0; e--; end
    qe = (e < -14) ? -24 : e - 10;
    q  = m / pow2(qe);
    fl = $floor(q);
    k  = longint'(fl);
    if ((q - fl > 0.5) || ((q - fl == 0.5) && (k % 2 == 1))) k++;
    r = real'(k) * pow2(qe);
    if (r >= 65536.0) return {s, 5'h1F, 10'd0};
    if (r < pow2(-14)) return {s, 5'd0, 10'(k)};
    t = r; e = 0;
    while (t >= 2.0) begin t = t / 2.0; e++; end
    while (t < 1.0)  begin t = t * 2.0; e--; end
    k = longint'(r / pow2(e - 10)) - 1024;
    return {s, 5'(e + 15), 10'(k)};
  endfunction

  function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    real d;
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b)) return (a[15] == b[15]) ? 16'h7E00 : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return {~b[15], 15'h7C00};
    d = h2r(a) - h2r(b);
    if (d == 0.0)
      return {a[15] & ~b[15] & (a[14:0] == 15'd0) & (b[14:0] == 15'd0), 15'd0};
    return r2h(d);
  endfunction

  function automatic beat_t ref_beat(input logic [W-1:0] a, input logic last, input logic [15:0] b);
    beat_t t;
    logic [15:0] r;
    t.last = last;
    t.clamp = 1'b0;
    t.data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      r = ref_sub(a[i*16 +: 16], b);
`ifdef MODE6_SUB_CLAMP_EN
      if (!r[15] && (r[14:0] != 15'd0) && !is_nan(r)) begin
        r = 16'h0000;
        t.clamp = 1'b1;
      end
`endif
      t.data[i*16 +: 16] = r;
    end
    return t;
  endfunction

  // Any NaN encoding is acceptable where the model expects NaN.
  function automatic bit vec_match(input logic [W-1:0] got, input logic [W-1:0] expv);
    bit ok = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (is_nan(expv[i*16 +: 16])) begin
        if (!is_nan(got[i*16 +: 16])) ok = 1'b0;
      end else if (got[i*16 +: 16] !== expv[i*16 +: 16]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [15:0] rand_half();
    logic [15:0] specials [12];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h3C00,
                 16'hBC00, 16'h0001, 16'h8001, 16'h03FF, 16'h7BFF, 16'hFBFF};
    case ($urandom % 6)
      0: return specials[$urandom % 12];
      1: return {1'($urandom), 5'd0, 10'($urandom)};
      2: return model_b + 16'($urandom_range(0, 6)) - 16'd3;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NUM_LANES; i++) v[i*16 +: 16] = rand_half();
    return v;
  endfunction

  task automatic idle_inputs();
    b_load = 1'b0; b_inp = 16'h0000; in_valid = 1'b0;
    a_inp = '0; in_last = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_b = 16'h0000;
    exp_q.delete();
  endtask

  // Present one beat until accepted; queue its model result.
  task automatic send_beat(input logic [W-1:0] a, input logic last, input logic ld,
                           input logic [15:0] bv, output bit ok);
    int n = 0;
    in_valid = 1'b1; a_inp = a; in_last = last; b_load = ld; b_inp = bv;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    ok = in_ready;
    exp_q.push_back(ref_beat(a, last, ld ? bv : model_b));
    if (ld) model_b = bv;
    @(negedge clk);
    in_valid = 1'b0; b_load = 1'b0;
  endtask

  // Wait for and take one output beat.
  task automatic recv_beat(output logic [W-1:0] data, output logic last,
                           output logic clamp, output bit ok);
    int n = 0;
    out_ready = 1'b1;
    #1;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    ok = out_valid; data = outp; last = out_last; clamp = clamp_hit;
    $display("[TB] beat out outp=%h last=%b clamp=%b", data, last, clamp);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] d; logic l, c; bit ok; beat_t e;
    resetn = 1'b0; b_load = 1'b1; b_inp = 16'h1234; in_valid = 1'b1;
    a_inp = rand_vec(); in_last = 1'b1; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk); @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || clamp_hit !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: valid=%b last=%b clamp=%b want 0", out_valid, out_last, clamp_hit);
    end
    tests_run++;
    if (beat_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %h want 0000", beat_count); end
    tests_run++;
    if (outp !== '0) begin tests_failed++; $display("FAIL reset_outp: got %h want 0", outp); end
    @(negedge clk);
    resetn = 1'b1; idle_inputs(); model_b = 16'h0000; exp_q.delete();
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    // b_held must come out of reset as +0, so a - b_held == a.
    send_beat({NUM_LANES{16'h3C00}}, 1'b1, 1'b0, 16'hFFFF, ok);
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || !vec_match(d, e.data) || l !== e.last) begin
      tests_failed++; $display("FAIL reset_b_held: got %h last %b want %h last %b", d, l, e.data, e.last);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] a; logic [15:0] want0; beat_t e;
    do_reset();
    b_load = 1'b1; b_inp = 16'h3C00;
    @(negedge clk);
    b_load = 1'b0; model_b = 16'h3C00;
    a = rand_vec(); a[15:0] = 16'h4000;
    e = ref_beat(a, 1'b0, model_b);
`ifdef MODE6_SUB_CLAMP_EN
    want0 = 16'h0000;
`else
    want0 = 16'h3C00;
`endif
    in_valid = 1'b1; a_inp = a; in_last = 1'b0; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_accept: in_ready %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_latency_early: out_valid %b want 0", out_valid); end
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || outp[15:0] !== want0) begin
      tests_failed++; $display("FAIL basic_lane0: valid %b lane0 %h want 1 %h", out_valid, outp[15:0], want0);
    end
    tests_run++;
    if (!vec_match(outp, e.data) || clamp_hit !== e.clamp) begin
      tests_failed++; $display("FAIL basic_lanes: got %h clamp %b want %h clamp %b", outp, clamp_hit, e.data, e.clamp);
    end
    $display("[TB] basic beat outp=%h", outp);
    @(negedge clk); #1;
    tests_run++;
    if (beat_count !== 16'd1 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_count: count %h valid %b want 0001 0", beat_count, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_sign();
    logic [W-1:0] d; logic l, c; bit ok;
    logic [15:0] want; logic want_c;
    do_reset();
    send_beat({NUM_LANES{16'h3C00}}, 1'b0, 1'b1, 16'h4000, ok);
    recv_beat(d, l, c, ok);
    tests_run++;
    if (!ok || d[15:0] !== 16'hBC00 || c !== 1'b0) begin
      tests_failed++; $display("FAIL sign_neg: lane0 %h clamp %b want bc00 0", d[15:0], c);
    end
`ifdef MODE6_SUB_CLAMP_EN
    want = 16'h0000; want_c = 1'b1;
`else
    want = 16'h4200; want_c = 1'b0;
`endif
    send_beat({NUM_LANES{16'h4400}}, 1'b1, 1'b1, 16'h3C00, ok);
    recv_beat(d, l, c, ok);
    tests_run++;
    if (!ok || d[15:0] !== want || c !== want_c || l !== 1'b1) begin
      tests_failed++; $display("FAIL sign_pos: lane0 %h clamp %b last %b want %h %b 1", d[15:0], c, l, want, want_c);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av [3];
    int acc = 0, got = 0;
    beat_t e;
    do_reset();
    for (int i = 0; i < 3; i++) av[i] = rand_vec();
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = 1'b1; a_inp = av[acc]; in_last = (acc == 1);
      b_load = (cyc == 0); b_inp = 16'h3C00; out_ready = 1'b0;
      #1;
      if (cyc >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || !vec_match(outp, exp_q[0].data)) begin
          tests_failed++; $display("FAIL bp_hold: valid %b outp %h want 1 %h", out_valid, outp, exp_q[0].data);
        end
      end
      if (in_ready) begin
        exp_q.push_back(ref_beat(av[acc], acc == 1, b_load ? b_inp : model_b));
        acc++;
      end
      if (b_load) model_b = b_inp;
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (acc != 2 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_accepts: accepted %0d in_ready %b want 2 0", acc, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; b_load = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (out_valid) begin
        got++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL bp_extra: unexpected beat %h", outp);
        end else begin
          e = exp_q.pop_front();
          if (!vec_match(outp, e.data) || out_last !== e.last) begin
            tests_failed++; $display("FAIL bp_order: got %h last %b want %h last %b", outp, out_last, e.data, e.last);
          end
        end
        $display("[TB] bp beat outp=%h last=%b", outp, out_last);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (got != 2 || beat_count !== 16'd2) begin
      tests_failed++; $display("FAIL bp_count: beats %0d count %h want 2 0002", got, beat_count);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    logic [W-1:0] d; logic l, c; bit ok; beat_t e;
    logic [15:0] want_p, want_q;
    do_reset();
`ifdef MODE6_SUB_CLAMP_EN
    want_p = 16'h0000; want_q = 16'h0000;
`else
    want_p = 16'h4200; want_q = 16'h4000;
`endif
    b_load = 1'b1; b_inp = 16'h3C00;
    @(negedge clk);
    b_load = 1'b0; model_b = 16'h3C00;
    out_ready = 1'b0;
    send_beat({NUM_LANES{16'h4400}}, 1'b0, 1'b0, 16'h0000, ok);
    send_beat({NUM_LANES{16'h4400}}, 1'b1, 1'b1, 16'h4000, ok);
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || d[15:0] !== want_p || !vec_match(d, e.data)) begin
      tests_failed++; $display("FAIL bypass_prior: lane0 %h got %h want %h", d[15:0], d, e.data);
    end
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || d[15:0] !== want_q || !vec_match(d, e.data) || l !== 1'b1) begin
      tests_failed++; $display("FAIL bypass_new: lane0 %h got %h want %h", d[15:0], d, e.data);
    end
    send_beat({NUM_LANES{16'h4400}}, 1'b0, 1'b0, 16'h0000, ok);
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || d[15:0] !== want_q || !vec_match(d, e.data)) begin
      tests_failed++; $display("FAIL bypass_held: lane0 %h want %h", d[15:0], want_q);
    end
  endtask

  task automatic test_specials();
    logic [W-1:0] a, d; logic l, c; bit ok; beat_t e;
    do_reset();
    a = rand_vec(); a[15:0] = 16'h7C00;
    send_beat(a, 1'b0, 1'b1, 16'h7C00, ok);
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || d[14:10] !== 5'h1F || d[9:0] == 10'd0) begin
      tests_failed++; $display("FAIL inf_minus_inf: lane0 %h want NaN", d[15:0]);
    end
    tests_run++;
    if (!vec_match(d, e.data) || c !== e.clamp) begin
      tests_failed++; $display("FAIL specials_lanes: got %h want %h", d, e.data);
    end
    for (int i = 0; i < NUM_LANES; i++) a[i*16 +: 16] = {1'($urandom), 5'd0, 10'($urandom)};
    send_beat(a, 1'b0, 1'b1, {1'($urandom), 5'd0, 10'($urandom)}, ok);
    recv_beat(d, l, c, ok);
    e = exp_q.pop_front();
    tests_run++;
    if (!ok || !vec_match(d, e.data) || c !== e.clamp) begin
      tests_failed++; $display("FAIL subnormal_lanes: got %h want %h", d, e.data);
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] d; logic l, c; bit ok; bit stale = 1'b0;
    do_reset();
    send_beat(rand_vec(), 1'b0, 1'b1, 16'h3C00, ok);
    recv_beat(d, l, c, ok);
    #1;
    tests_run++;
    if (beat_count !== 16'd1) begin tests_failed++; $display("FAIL midrst_pre: count %h want 0001", beat_count); end
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(rand_vec(), 1'b0, 1'b0, 16'h0000, ok);
    send_beat(rand_vec(), 1'b1, 1'b0, 16'h0000, ok);
    resetn = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || beat_count !== 16'd0 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_clear: valid %b count %h ready %b want 0 0000 0", out_valid, beat_count, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1; out_ready = 1'b1; exp_q.delete();
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (out_valid) stale = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (stale) begin tests_failed++; $display("FAIL midrst_stale: stale beat seen after reset, want none"); end
  endtask

  task automatic test_random();
    int delivered = 0;
    beat_t e;
    logic [15:0] bnow;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid = ($urandom % 4) != 0;
      a_inp = rand_vec();
      in_last = 1'($urandom);
      b_load = (cyc == 0) || (($urandom % 8) == 0);
      b_inp = rand_half();
      out_ready = ($urandom % 4) != 0;
      #1;
      if (out_valid && out_ready) begin
        delivered++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rand_extra: unexpected beat %h", outp);
        end else begin
          e = exp_q.pop_front();
          if (!vec_match(outp, e.data) || out_last !== e.last || clamp_hit !== e.clamp) begin
            tests_failed++;
            $display("FAIL rand_beat: got %h last %b clamp %b want %h last %b clamp %b",
                     outp, out_last, clamp_hit, e.data, e.last, e.clamp);
          end
        end
        $display("[TB] rand beat %0d outp=%h", delivered, outp);
      end
      bnow = b_load ? b_inp : model_b;
      if (in_valid && in_ready) exp_q.push_back(ref_beat(a_inp, in_last, bnow));
      if (b_load) model_b = b_inp;
      @(negedge clk);
    end
    in_valid = 1'b0; b_load = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (out_valid) begin
        delivered++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rand_drain_extra: unexpected beat %h", outp);
        end else begin
          e = exp_q.pop_front();
          if (!vec_match(outp, e.data) || out_last !== e.last || clamp_hit !== e.clamp) begin
            tests_failed++; $display("FAIL rand_drain: got %h want %h", outp, e.data);
          end
        end
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (exp_q.size() != 0 || beat_count !== 16'(delivered)) begin
      tests_failed++; $display("FAIL rand_totals: pending %0d count %h want 0 %h", exp_q.size(), beat_count, 16'(delivered));
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int delivered = 0;
    bit seen_top = 1'b0, done = 1'b0;
    do_reset();
    in_valid = 1'b1; a_inp = {NUM_LANES{16'h3C00}}; out_ready = 1'b1;
    for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
      #1;
      if (delivered == 65535 && !seen_top) begin
        seen_top = 1'b1;
        tests_run++;
        if (beat_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_top: count %h want ffff", beat_count); end
      end
      if (delivered == 65536) begin
        done = 1'b1;
        tests_run++;
        if (beat_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: count %h want 0000", beat_count); end
      end
      if (out_valid && out_ready) delivered++;
      @(negedge clk);
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("FAIL wrap_timeout: delivered %0d want 65536", delivered);
    end
    in_valid = 1'b0;
    $display("[TB] wrap delivered %0d beats", delivered);
  endtask

  initial begin
    resetn = 1'b0;
    model_b = 16'h0000;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_bypass();
    test_specials();
    test_reset_midflight();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
